// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-requester SRAM port arbiter.
// The default macro is 256 x 48 with 8 write lanes of 6 bits.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 48;
    localparam int MASK_W_DEF = 8;

    // One request as presented by a requester (sized for the default macro)
    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [MASK_W_DEF-1:0] wmask;
        logic [DATA_W_DEF-1:0] wdata;
    } sram_req_t;

    // INIT clears the macro after reset (only reachable with SRAM_ARB_INIT_EN)
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_arb_resp_slot.sv
// Per-requester read response slot. Tracks one outstanding read, forwards the
// macro output in the cycle it is valid, and parks it in a hold register if the
// consumer stalls, so a later access by the other requester cannot corrupt it.
module sram_arb_resp_slot
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_issue,
    input  logic              i_resp_ready,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata
);

    logic              r_pend;
    logic              r_rd_vld_p1;
    logic [DATA_W-1:0] r_hold_p2;

    // Control: pending response flag and "macro output is ours this cycle" marker
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= i_issue;
            if (i_issue)
                r_pend <= 1'b1;
            else if (r_pend && i_resp_ready)
                r_pend <= 1'b0;
        end
    end

    // Data: capture the macro output when the response is not taken on arrival
    always_ff @(posedge clock) begin
        if (r_rd_vld_p1 && !i_resp_ready)
            r_hold_p2 <= i_sram_rdata;
    end

    // Output mux: fresh macro data on arrival, hold register afterwards, 0 when empty
    always_comb begin
        o_resp_valid = r_pend;
        o_resp_rdata = '0;
        if (r_pend)
            o_resp_rdata = r_rd_vld_p1 ? i_sram_rdata : r_hold_p2;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-read, lane-masked SRAM
// between requester 0 (lookup/fetch) and requester 1 (refill/update).
// Optional macro SRAM_ARB_INIT_EN: after reset, sweep every address writing
// zeros with a full mask before accepting requests.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [MASK_W-1:0] req0_wmask,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [MASK_W-1:0] req1_wmask,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

`ifdef SRAM_ARB_INIT_EN
    localparam arb_state_e RST_STATE = INIT;
`else
    localparam arb_state_e RST_STATE = RUN;
`endif

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr;
    logic              r_ptr;        // requester that wins the next tie
    logic              w_init_busy;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;
    sram_req_t         w_req0;
    sram_req_t         w_req1;
    sram_req_t         w_sel;

    // State register: reset always restarts from the build's entry state
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= RST_STATE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last address has been cleared
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (&r_init_addr) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    // Clear-sweep address, restarts at 0 on reset and idles at 0 outside INIT
    always_ff @(posedge clock) begin
        if (reset || r_state != INIT)
            r_init_addr <= '0;
        else
            r_init_addr <= r_init_addr + 1'b1;
    end

    assign init_done   = (r_state == RUN) && !reset;
    assign w_init_busy = (r_state == INIT) && !reset;

    // A read needs a free (or freeing) response slot; writes never wait on it
    assign w_elig0 = req0_valid && (req0_write || !resp0_valid || resp0_ready);
    assign w_elig1 = req1_valid && (req1_write || !resp1_valid || resp1_ready);

    assign w_gnt0 = init_done && w_elig0 && (!w_elig1 || !r_ptr);
    assign w_gnt1 = init_done && w_elig1 && (!w_elig0 ||  r_ptr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Round-robin pointer: points away from the most recent winner
    always_ff @(posedge clock) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (w_gnt0)
            r_ptr <= 1'b1;
        else if (w_gnt1)
            r_ptr <= 1'b0;
    end

    assign w_req0 = '{write: req0_write, addr: req0_addr, wmask: req0_wmask, wdata: req0_wdata};
    assign w_req1 = '{write: req1_write, addr: req1_addr, wmask: req1_wmask, wdata: req1_wdata};
    assign w_sel  = w_gnt1 ? w_req1 : w_req0;

    // Macro drive: clear sweep, else the granted request, else idle zeros
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (w_init_busy) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = r_init_addr;
            sram_wmask = '1;
        end else if (w_gnt0 || w_gnt1) begin
            sram_en    = 1'b1;
            sram_wmode = w_sel.write;
            sram_addr  = w_sel.addr;
            sram_wmask = w_sel.wmask;
            sram_wdata = w_sel.wdata;
        end
    end

    sram_arb_resp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clock        (clock),
        .reset        (reset),
        .i_issue      (w_gnt0 && !req0_write),
        .i_resp_ready (resp0_ready),
        .i_sram_rdata (sram_rdata),
        .o_resp_valid (resp0_valid),
        .o_resp_rdata (resp0_rdata)
    );

    sram_arb_resp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clock        (clock),
        .reset        (reset),
        .i_issue      (w_gnt1 && !req1_write),
        .i_resp_ready (resp1_ready),
        .i_sram_rdata (sram_rdata),
        .o_resp_valid (resp1_valid),
        .o_resp_rdata (resp1_rdata)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 256 x 48 lane-masked
// SRAM model. Build with SRAM_ARB_INIT_EN defined to cover the clear sweep.
module tb_sram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write;
    logic [7:0]  req0_addr, req0_wmask;
    logic [47:0] req0_wdata;
    logic        resp0_valid, resp0_ready;
    logic [47:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [7:0]  req1_addr, req1_wmask;
    logic [47:0] req1_wdata;
    logic        resp1_valid, resp1_ready;
    logic [47:0] resp1_rdata;
    logic        sram_en, sram_wmode;
    logic [7:0]  sram_addr, sram_wmask;
    logic [47:0] sram_wdata, m_rdata;
    logic        init_done;

    logic [47:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    sram_port_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rdata(resp1_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(m_rdata),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    // SRAM model: reset fills with all-ones so a clear sweep is visible
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '1;
        end else if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < 8; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*6 +: 6] <= sram_wdata[l*6 +: 6];
            end else begin
                m_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] cval(input int i);
        return 48'h111111111111 * 48'(i + 1);
    endfunction

    // Issue one request and wait (bounded) for its grant; returns at posedge+1
    task automatic do_req(input bit n, input logic wr, input logic [7:0] a,
                          input logic [7:0] m, input logic [47:0] d);
        bit ok;
        ok = 1'b0;
        if (!n) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wmask = m; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wmask = m; req1_wdata = d;
        end
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            ok = n ? req1_ready : req0_ready;
        end
        chk("req_grant", 64'(ok), 64'd1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_read(input bit n, input logic [7:0] a, input logic [47:0] exp, input string tag);
        do_req(n, 1'b0, a, 8'h00, 48'h0);
        @(negedge clock);
        chk({tag, "_vld"}, 64'(n ? resp1_valid : resp0_valid), 64'd1);
        chk(tag, 64'(n ? resp1_rdata : resp0_rdata), 64'(exp));
        @(posedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [7:0] a0, a1;
        reset = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h77; req0_wmask = 8'h00; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wmask = 8'h00; req1_wdata = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        // Reset state (req0 already presenting a read)
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rdy0", 64'(req0_ready), 64'd0);
        chk("rst_rdy1", 64'(req1_ready), 64'd0);
        chk("rst_rvld0", 64'(resp0_valid), 64'd0);
        chk("rst_rvld1", 64'(resp1_valid), 64'd0);
        chk("rst_rdata0", 64'(resp0_rdata), 64'd0);
        chk("rst_en", 64'(sram_en), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

`ifdef SRAM_ARB_INIT_EN
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            chk("init_done_lo", 64'(init_done), 64'd0);
            chk("init_rdy0", 64'(req0_ready), 64'd0);
            chk("init_en", 64'(sram_en && sram_wmode), 64'd1);
            chk("init_addr", 64'(sram_addr), 64'(i));
        end
`endif
        @(negedge clock);
        chk("init_done_hi", 64'(init_done), 64'd1);
        chk("first_rdy0", 64'(req0_ready), 64'd1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        chk("first_rd_vld", 64'(resp0_valid), 64'd1);
`ifdef SRAM_ARB_INIT_EN
        chk("first_rd_data", 64'(resp0_rdata), 64'h0);
`else
        chk("first_rd_data", 64'(resp0_rdata), 64'hFFFFFFFFFFFF);
`endif
        @(posedge clock); #1;

        // Single read
        do_req(1'b1, 1'b1, 8'h10, 8'hFF, 48'hABCDEF012345);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h10;
        @(negedge clock);
        chk("sr_rdy0", 64'(req0_ready), 64'd1);
        chk("sr_en", 64'(sram_en), 64'd1);
        chk("sr_wmode", 64'(sram_wmode), 64'd0);
        chk("sr_addr", 64'(sram_addr), 64'h10);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        chk("sr_rvld", 64'(resp0_valid), 64'd1);
        chk("sr_rdata", 64'(resp0_rdata), 64'hABCDEF012345);
        @(negedge clock);
        chk("sr_drained", 64'(resp0_valid), 64'd0);
        @(posedge clock); #1;

        // Masked writes: lane 0 and lane 7
        do_req(1'b1, 1'b1, 8'h20, 8'hFF, 48'hFFFFFFFFFFC0);
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h20; req1_wmask = 8'h01; req1_wdata = 48'h00000000003F;
        @(negedge clock);
        chk("mw_wmode", 64'(sram_wmode), 64'd1);
        chk("mw_wmask", 64'(sram_wmask), 64'h01);
        @(posedge clock); #1;
        req1_valid = 1'b0;
        do_read(1'b1, 8'h20, 48'hFFFFFFFFFFFF, "mw_lane0");
        do_req(1'b1, 1'b1, 8'h21, 8'hFF, 48'h0);
        do_req(1'b1, 1'b1, 8'h21, 8'h80, 48'hFFFFFFFFFFFF);
        do_read(1'b1, 8'h21, 48'hFC0000000000, "mw_lane7");

        // Contention: pointer favours requester 0 after the last req1 grant
        for (int i = 0; i < 6; i++) do_req(1'b1, 1'b1, 8'(8'h30 + i), 8'hFF, cval(i));
        a0 = 8'h30; a1 = 8'h31;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = a0;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = a1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("ct_rdy0", 64'(req0_ready), 64'(c % 2 == 0));
            chk("ct_rdy1", 64'(req1_ready), 64'(c % 2 == 1));
            chk("ct_addr", 64'(sram_addr), 64'(8'h30 + c));
            if (c > 0) begin
                chk("ct_rvld", 64'((c % 2 == 1) ? resp0_valid : resp1_valid), 64'd1);
                chk("ct_rdata", 64'((c % 2 == 1) ? resp0_rdata : resp1_rdata), 64'(cval(c - 1)));
            end
            @(posedge clock); #1;
            if (c % 2 == 0) a0 = a0 + 8'd2; else a1 = a1 + 8'd2;
            req0_addr = a0; req1_addr = a1;
            if (c == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        @(negedge clock);
        chk("ct_rvld_last", 64'(resp1_valid), 64'd1);
        chk("ct_rdata_last", 64'(resp1_rdata), 64'(cval(5)));
        @(posedge clock); #1;

        // Backpressure on requester 0
        do_req(1'b1, 1'b1, 8'h05, 8'hFF, 48'h0A0A0A0A0A0A);
        do_req(1'b1, 1'b1, 8'h06, 8'hFF, 48'h0B0B0B0B0B0B);
        do_req(1'b1, 1'b1, 8'h07, 8'hFF, 48'h0C0C0C0C0C0C);
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h05;
        @(negedge clock);
        chk("bp_rdy0_first", 64'(req0_ready), 64'd1);
        @(posedge clock); #1;
        req0_addr = 8'h07;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h06;
        @(negedge clock);
        chk("bp_rdata_t1", 64'(resp0_rdata), 64'h0A0A0A0A0A0A);
        chk("bp_rdy0_t1", 64'(req0_ready), 64'd0);
        chk("bp_rdy1_t1", 64'(req1_ready), 64'd1);
        @(posedge clock); #1;
        req1_write = 1'b1; req1_addr = 8'h05; req1_wmask = 8'hFF; req1_wdata = 48'h0;
        @(negedge clock);
        chk("bp_resp1_vld", 64'(resp1_valid), 64'd1);
        chk("bp_resp1_data", 64'(resp1_rdata), 64'h0B0B0B0B0B0B);
        chk("bp_wr_rdy1", 64'(req1_ready), 64'd1);
        for (int t = 2; t < 5; t++) begin
            if (t > 2) @(negedge clock);
            chk("bp_hold_vld", 64'(resp0_valid), 64'd1);
            chk("bp_hold_data", 64'(resp0_rdata), 64'h0A0A0A0A0A0A);
            chk("bp_rdy0_stall", 64'(req0_ready), 64'd0);
            @(posedge clock); #1;
            req1_valid = 1'b0;
        end
        resp0_ready = 1'b1;
        @(negedge clock);
        chk("bp_take_data", 64'(resp0_rdata), 64'h0A0A0A0A0A0A);
        chk("bp_rdy0_again", 64'(req0_ready), 64'd1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        chk("bp_second_vld", 64'(resp0_valid), 64'd1);
        chk("bp_second_data", 64'(resp0_rdata), 64'h0C0C0C0C0C0C);
        @(posedge clock); #1;

        // Reset while a read is in flight (pointer currently favours req1)
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h10;
        @(negedge clock);
        chk("mr_rdy0", 64'(req0_ready), 64'd1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("mr_en_rst", 64'(sram_en), 64'd0);
        @(negedge clock);
        chk("mr_rvld", 64'(resp0_valid), 64'd0);
        chk("mr_rdata", 64'(resp0_rdata), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clock);
            ok = init_done;
        end
        chk("mr_init_done", 64'(ok), 64'd1);
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h10;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h11;
        @(negedge clock);
        chk("mr_ptr_rdy0", 64'(req0_ready), 64'd1);
        chk("mr_ptr_rdy1", 64'(req1_ready), 64'd0);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        chk("mr_next_rdy1", 64'(req1_ready), 64'd1);
        @(posedge clock); #1;
        req1_valid = 1'b0;
        repeat (2) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read, lane-masked SRAM macro between two requesters. The macro is 256 x 48 with 8 lanes of 6 bits.
- Requester 0 is typically a lookup/fetch path; requester 1 is a refill/update path.
- Round-robin arbitration with valid/ready request handshakes.
- Each requester has its own response slot with backpressure. Read data is captured before the macro's output can change.

Parameters:
- ADDR_W, 8, SRAM address width (depth 2^ADDR_W).
- DATA_W, 48, SRAM word width.
- MASK_W, 8, write-mask lanes; lane width = DATA_W/MASK_W (6).

Ports:
- clock  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request present (N = 0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_write  in  1  1 = masked write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wmask  in  MASK_W  lane enables (writes only)
- reqN_wdata  in  DATA_W  write data
- respN_valid  out  1  read data available
- respN_ready  in  1  consumer takes response
- respN_rdata  out  DATA_W  read data
- sram_en  out  1  macro enable
- sram_wmode  out  1  macro write mode
- sram_addr  out  ADDR_W  macro address
- sram_wmask  out  MASK_W  macro lane mask
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable
- init_done  out  1  arbiter accepting requests

Behaviour:
- Reset values: reqN_ready=0, respN_valid=0, sram_en=0, respN_rdata=0, round-robin pointer = requester 0. init_done=0 during reset.
- Eligibility:
  - Writes are always eligible.
  - A read from N is eligible only if N's response slot is empty, or is being drained this cycle (respN_valid && respN_ready).
  - A requester therefore has at most one read outstanding.
- Grant:
  - At most one grant per cycle, and only when init_done=1.
  - If both requesters are eligible, grant goes to the one not granted most recently. The pointer flips only on a grant.
  - reqN_ready = grant; it may depend combinationally on both valids.
  - A transfer occurs on reqN_valid && reqN_ready.
- SRAM drive: in the grant cycle, sram_en=1, sram_wmode=write, and addr/wmask/wdata are passed straight through. When idle, sram_en=0 and the other SRAM outputs are don't-care (drive 0).
- Read latency:
  - A read granted at cycle T sets respN_valid=1 at T+1, with respN_rdata = sram_rdata.
  - If the response is not taken at T+1, sram_rdata is captured into N's hold register at the end of T+1. From T+2, respN_rdata comes from the hold register, stable until taken.
  - Fastest case is back-to-back reads by the same requester: respN_ready is high every cycle, giving 1 read per cycle.
- Writes produce no response. A write after a pending read to the same address does not alter the held data.
- A write and a read cannot be issued in the same cycle (single port); the arbiter never asserts both readies.
- Reset asserted mid-operation: pending and held responses are discarded, respN_valid=0 on the next cycle, pointer returns to 0.

Optional Feature:
- Macro SRAM_ARB_INIT_EN.
- Defined:
  - After reset deasserts, an INIT state sweeps addresses 0..2^ADDR_W-1, one per cycle, writing all-zero data with an all-ones mask.
  - Request readies stay 0 throughout INIT.
  - init_done rises the cycle after address 255 is written: cycle 256 after the first non-reset cycle. State then goes to RUN.
  - Reset during INIT restarts the sweep at address 0.
- Not defined: init_done is constant 1 outside reset and there is no clear sweep; RUN is entered directly.

Decomposition:
- Package sram_arb_pkg holds:
  - ADDR_W/DATA_W/MASK_W defaults;
  - the request bundle typedef (write, addr, wmask, wdata);
  - the state enum {INIT, RUN}.
- Sub-module sram_arb_resp_slot contains the per-requester pending flag, hold register and output mux. It is instantiated twice.

Test Plan:
- Single read:
  - Preload addr 0x10 = 0xABCDEF012345; req0 reads 0x10 at T.
  - Expect sram_en=1, sram_wmode=0 at T; resp0_valid=1 with rdata 0xABCDEF012345 at T+1.
- Masked write:
  - req1 writes addr 0x20, wmask 0x01, wdata 0x00000000003F over old 0xFFFFFFFFFFC0.
  - A subsequent read returns 0xFFFFFFFFFFFF. Only lane 0 is written.
- Contention:
  - req0 and req1 both hold valid reads for 6 cycles, with both resp_ready=1.
  - Grants alternate 0,1,0,1,0,1 starting with requester 0 after reset. Each requester gets 3 responses with correct data.
- Backpressure:
  - req0 reads 0x05 (data A); resp0_ready=0 for 4 cycles while req1 reads 0x06 (data B).
  - resp0_rdata stays A throughout. req0 gets no second read grant until A is taken.
- Reset mid-flight: assert reset the cycle a read is granted. Expect resp0_valid=0 the next cycle and the pointer back at 0.
- SRAM_ARB_INIT_EN:
  - Expect init_done=0 and req0_ready=0 for 256 cycles after reset, with sram_addr walking 0..255.
  - A subsequent read of any address returns 0.
